// File: rtl/registers_bank_pkg.sv
// Shared core constants for the MIPS register file.
package registers_bank_pkg;
  localparam int ARQUITECTURE_BITS = 32;
  localparam int NUM_REGISTERS     = 32;
  localparam int REGISTER_ZERO     = 0;
  localparam int NUM_READ_PORTS    = 2;
endpackage

// File: rtl/register_read_port.sv
// Next-cycle value of one read bus: stored row, or write-back data when the
// same non-zero register is being written on this edge.
module register_read_port
  import registers_bank_pkg::*;
#(
  parameter int BUS_SIZE  = ARQUITECTURE_BITS,
  parameter int ADDR_SIZE = $clog2(NUM_REGISTERS)
) (
  input  logic [BUS_SIZE-1:0]  row,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic                 write_enable,
  input  logic [ADDR_SIZE-1:0] addr_wr,
  input  logic [BUS_SIZE-1:0]  data_wr,
  output logic [BUS_SIZE-1:0]  next
);
  logic is_zero;
  assign is_zero = (addr == ADDR_SIZE'(REGISTER_ZERO));

  always_comb begin
    next = row;
    if (is_zero)
      next = '0;
    else if (write_enable && addr == addr_wr)
      next = data_wr;
  end
endmodule

// File: rtl/registers_bank.sv
// 32-entry GPR file: two registered read ports with write-first bypass,
// one write-back port and a combinational debug read port.
module registers_bank
  import registers_bank_pkg::*;
#(
  parameter int REGISTERS = NUM_REGISTERS,
  parameter int BUS_SIZE  = ARQUITECTURE_BITS,
  parameter int ADDR_SIZE = $clog2(REGISTERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 write_enable,
  input  logic [ADDR_SIZE-1:0] addr_wr,
  input  logic [BUS_SIZE-1:0]  data_wr,
  input  logic [ADDR_SIZE-1:0] addr_a,
  input  logic [ADDR_SIZE-1:0] addr_b,
  output logic [BUS_SIZE-1:0]  bus_a,
  output logic [BUS_SIZE-1:0]  bus_b,
  input  logic [ADDR_SIZE-1:0] addr_debug,
  output logic [BUS_SIZE-1:0]  data_debug
);
  logic [BUS_SIZE-1:0] regs [REGISTERS];

  logic [NUM_READ_PORTS-1:0][ADDR_SIZE-1:0] rd_addr;
  logic [NUM_READ_PORTS-1:0][BUS_SIZE-1:0]  rd_row;
  logic [NUM_READ_PORTS-1:0][BUS_SIZE-1:0]  rd_next;
  logic [NUM_READ_PORTS-1:0][BUS_SIZE-1:0]  rd_bus;

  assign rd_addr = {addr_b, addr_a};

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    assign rd_row[p] = regs[rd_addr[p]];
    register_read_port #(.BUS_SIZE(BUS_SIZE), .ADDR_SIZE(ADDR_SIZE)) u_port (
      .row          (rd_row[p]),
      .addr         (rd_addr[p]),
      .write_enable (write_enable),
      .addr_wr      (addr_wr),
      .data_wr      (data_wr),
      .next         (rd_next[p])
    );
  end

  // Write-back is independent of enable so in-flight instructions retire during stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGISTERS; i++) regs[i] <= '0;
    end else if (write_enable && addr_wr != ADDR_SIZE'(REGISTER_ZERO)) begin
      regs[addr_wr] <= data_wr;
    end
  end

  // Flush outranks stall so a bubble can be inserted while the front end is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       rd_bus <= '0;
    else if (flush)  rd_bus <= '0;
    else if (enable) rd_bus <= rd_next;
  end

  assign bus_a      = rd_bus[0];
  assign bus_b      = rd_bus[1];
  assign data_debug = regs[addr_debug];
endmodule

// File: tb/tb_registers_bank.sv
// Directed self-checking bench for registers_bank.
module tb_registers_bank;
  logic        clk = 1'b0;
  logic        reset, enable, flush, write_enable;
  logic [4:0]  addr_wr, addr_a, addr_b, addr_debug;
  logic [31:0] data_wr, bus_a, bus_b, data_debug;
  int tests = 0;
  int fails = 0;

  registers_bank dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .write_enable(write_enable), .addr_wr(addr_wr), .data_wr(data_wr),
    .addr_a(addr_a), .addr_b(addr_b), .bus_a(bus_a), .bus_b(bus_b),
    .addr_debug(addr_debug), .data_debug(data_debug)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    write_enable = 1'b1; addr_wr = a; data_wr = d;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    for (int i = 1; i < 32; i++) wr(5'(i), $urandom | 32'h1);
    addr_a = 5'd4; addr_b = 5'd17; enable = 1'b1;
    tick();
    #2 reset = 1'b1;
    #1;
    check("reset_bus_a", bus_a, 32'h0);
    check("reset_bus_b", bus_b, 32'h0);
    // write attempted while reset is held must be lost
    write_enable = 1'b1; addr_wr = 5'd6; data_wr = 32'hCAFE_F00D;
    tick();
    write_enable = 1'b0;
    for (int i = 0; i < 32; i++) begin
      addr_debug = 5'(i);
      #1;
      check("reset_debug", data_debug, 32'h0);
    end
    check("reset_hold_bus_a", bus_a, 32'h0);
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    wr(5'd5, 32'hDEAD_BEEF);
    addr_a = 5'd5;
    tick();
    check("wr_rd_bus_a", bus_a, 32'hDEAD_BEEF);
    addr_debug = 5'd5; #1;
    check("wr_rd_debug5", data_debug, 32'hDEAD_BEEF);
  endtask

  task automatic test_reg_zero();
    write_enable = 1'b1; addr_wr = 5'd0; data_wr = 32'h1234_5678;
    addr_a = 5'd0; addr_b = 5'd0;
    tick();
    write_enable = 1'b0;
    tick();
    check("r0_bus_a", bus_a, 32'h0);
    check("r0_bus_b", bus_b, 32'h0);
    addr_debug = 5'd0; #1;
    check("r0_debug", data_debug, 32'h0);
  endtask

  task automatic test_bypass();
    wr(5'd9, 32'h1);
    addr_a = 5'd9; addr_b = 5'd9;
    write_enable = 1'b1; addr_wr = 5'd9; data_wr = 32'hA5A5_A5A5;
    addr_debug = 5'd9; #1;
    check("bypass_debug_before", data_debug, 32'h1);
    tick();
    write_enable = 1'b0;
    check("bypass_bus_a", bus_a, 32'hA5A5_A5A5);
    check("bypass_bus_b", bus_b, 32'hA5A5_A5A5);
    check("bypass_debug_after", data_debug, 32'hA5A5_A5A5);
  endtask

  task automatic test_stall();
    wr(5'd3, 32'h11);
    addr_a = 5'd3;
    tick();
    check("stall_pre", bus_a, 32'h11);
    enable = 1'b0;
    write_enable = 1'b1; addr_wr = 5'd3; data_wr = 32'h22;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", bus_a, 32'h11);
    end
    write_enable = 1'b0;
    enable = 1'b1;
    tick();
    check("stall_release", bus_a, 32'h22);
  endtask

  task automatic test_flush();
    addr_a = 5'd5; addr_b = 5'd9;
    tick();
    check("flush_pre_a", bus_a, 32'hDEAD_BEEF);
    enable = 1'b0; flush = 1'b1;
    write_enable = 1'b1; addr_wr = 5'd7; data_wr = 32'h77;
    tick();
    flush = 1'b0; write_enable = 1'b0; enable = 1'b1;
    check("flush_bus_a", bus_a, 32'h0);
    check("flush_bus_b", bus_b, 32'h0);
    addr_debug = 5'd7; #1;
    check("flush_debug7", data_debug, 32'h77);
  endtask

  task automatic test_back_to_back();
    addr_a = 5'd10; addr_b = 5'd11;
    write_enable = 1'b1; addr_wr = 5'd10; data_wr = 32'h1010_1010;
    tick();
    check("b2b_a_bypass", bus_a, 32'h1010_1010);
    addr_wr = 5'd11; data_wr = 32'h1111_1111;
    tick();
    write_enable = 1'b0;
    check("b2b_a_stored", bus_a, 32'h1010_1010);
    check("b2b_b_bypass", bus_b, 32'h1111_1111);
    addr_a = 5'd11; addr_b = 5'd10;
    tick();
    check("b2b_swap_a", bus_a, 32'h1111_1111);
    check("b2b_swap_b", bus_b, 32'h1010_1010);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; flush = 1'b0; write_enable = 1'b0;
    addr_wr = '0; data_wr = '0; addr_a = '0; addr_b = '0; addr_debug = '0;
    #1;
    check("por_bus_a", bus_a, 32'h0);
    check("por_bus_b", bus_b, 32'h0);
    tick();
    reset = 1'b0;
    test_reset();
    test_write_read();
    test_reg_zero();
    test_bypass();
    test_stall();
    test_flush();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/registers_bank.md
# registers_bank

General-purpose register file of the MIPS core: 32 registers of `ARQUITECTURE_BITS` bits, two read ports and one write port. It sits in the decode stage directly upstream of the EX-stage operand muxes; its registered read data drives channel 0 of those forwarding muxes. A third, combinational read port serves the debug unit. Write data comes from write-back.

## Interface
- `REGISTERS`, 32: number of registers; power of two.
- `BUS_SIZE`, `ARQUITECTURE_BITS` (32): register width.
- `ADDR_SIZE`, $clog2(REGISTERS) (5): address width.

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears every register and output.
- `enable`  in  1  pipeline advance; low = stall (debug halt or hazard).
- `flush`  in  1  synchronous bubble insertion on read outputs.
- `write_enable`  in  1  write-back request.
- `addr_wr`  in  ADDR_SIZE  write-back destination.
- `data_wr`  in  BUS_SIZE  write-back data.
- `addr_a`, `addr_b`  in  ADDR_SIZE  read addresses (rs, rt).
- `bus_a`, `bus_b`  out  BUS_SIZE  registered read data for the EX stage.
- `addr_debug`  in  ADDR_SIZE  debug read address.
- `data_debug`  out  BUS_SIZE  combinational debug read data.

## Operation
- Storage: REGISTERS x BUS_SIZE. Register 0 always reads 0. Writes to address 0 are discarded.
- Write: if `write_enable` and `addr_wr != 0`, the rising edge stores `data_wr` at `addr_wr`. Writes do not depend on `enable`, so write-back of an instruction already in flight completes during a stall.
- Read capture on each rising edge, in this priority order:
  - `flush` = 1: `bus_a` and `bus_b` load 0. Flush wins over stall.
  - `enable` = 0: `bus_a` and `bus_b` hold their values.
  - Otherwise, each bus loads the register at its address.
- Write-first bypass: if a read address equals `addr_wr`, `write_enable` = 1 and the address is not 0, the bus loads `data_wr`, not the stale stored value. This holds for both ports at once, including `addr_a == addr_b == addr_wr`.
- Debug port: `data_debug` = storage[`addr_debug`], combinational, with no bypass. It reflects writes from the cycle after the write edge. An X or Z address yields X.
- Reset: all storage, `bus_a` and `bus_b` go to 0 immediately, with no clock edge needed. While `reset` is high, writes and captures are ignored.
- After `reset` deasserts, the first rising edge behaves normally.

## Timing
- Read latency: one cycle from address to `bus_a`/`bus_b`. Addresses presented before edge N appear on the buses after edge N.
- Write visibility:
  - Same-edge reads get the written value through the bypass.
  - The debug port shows it after the write edge.
- Stall: the buses hold for exactly as many edges as `enable` stays low. Storage writes keep occurring.
- Reset mid-operation: outputs go to 0 asynchronously. Any write pending on that edge is lost.
- Simultaneous `flush` and `write_enable`: the write is still performed and the buses go to 0.
- All outputs reset to 0.

## Structure
- `ARQUITECTURE_BITS` and the register count come from the shared `tb.vh`/core defines header. Add a `REGISTER_ZERO` constant there.
- Single module. The read-with-bypass logic is identical for both ports, so factor it into one sub-module, `register_read_port`. It takes storage row data, the read address and the write-back signals, and produces the next bus value.
- No memory primitive inference is required: a flop array with async reset.

## Test plan
- Reset: fill random values, pulse `reset` mid-cycle.
  - `bus_a`, `bus_b` = 0 immediately.
  - `data_debug` = 0 for all 32 addresses.
- Write then read: write 0xDEADBEEF to r5, then set `addr_a`=5.
  - `bus_a` = 0xDEADBEEF after the next edge.
  - `data_debug`(5) = 0xDEADBEEF.
- Register zero: write 0x12345678 to r0 and read r0 on both ports.
  - `bus_a` = `bus_b` = 0.
  - `data_debug`(0) = 0.
- Bypass: on the same edge, write 0xA5A5A5A5 to r9 with `addr_a` = `addr_b` = 9 (r9 previously 0x1).
  - Both buses = 0xA5A5A5A5 after that edge.
- Stall: `bus_a` = 0x11 from r3; drop `enable` for 3 edges while writing 0x22 to r3.
  - `bus_a` stays 0x11 for the 3 edges.
  - `bus_a` = 0x22 on the first edge with `enable` high.
- Flush priority: assert `flush` with `enable` = 0 and valid addresses.
  - Buses = 0 after the edge.
  - A concurrent write to r7 of 0x77 is visible on `data_debug`(7).
